// File: rtl/piso_readout_tx_if.sv
// Frame handshake and serial readout bundle for piso_readout_tx.
// The master side supplies frames and hold; the slave side is the transmitter.
interface piso_readout_tx_if #(
  parameter int WIDTH = 512
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             hold;
  logic             serial_out;
  logic             bit_valid;
  logic             last_bit;
  logic             busy;

  modport master (
    output data_in, data_valid, hold,
    input  data_ready, serial_out, bit_valid, last_bit, busy
  );

  modport slave (
    input  data_in, data_valid, hold,
    output data_ready, serial_out, bit_valid, last_bit, busy
  );
endinterface

// File: rtl/piso_readout_tx.sv
// Parallel-in/serial-out readout transmitter: accepts a WIDTH-bit frame and
// shifts it out MSB first, one bit per non-held clock, with valid/last strobes.
module piso_readout_tx #(
  parameter  int WIDTH = 512,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             reset,
  piso_readout_tx_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] shreg_r, shreg_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             data_ready_s;
  logic             accept_s;
  logic             serial_out_r;
  logic             bit_valid_r;
  logic             last_bit_r;
  logic             busy_r;

  // Ready depends only on state, counter and hold so upstream never sees a loop.
  always_comb begin
    data_ready_s = 1'b0;
    if (state_r == ST_IDLE) begin
      data_ready_s = 1'b1;
    end else if ((state_r == ST_SHIFT) && (cnt_r == CNT_ZERO) && !bus.hold) begin
      data_ready_s = 1'b1;
    end else begin
      data_ready_s = 1'b0;
    end
  end

  assign accept_s = bus.data_valid & data_ready_s;

  // Next-state, shift register and counter update.
  always_comb begin
    state_nxt_s = state_r;
    shreg_nxt_s = shreg_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_SHIFT;
          shreg_nxt_s = bus.data_in;
          cnt_nxt_s   = CNT_MAX;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bus.hold) begin
          state_nxt_s = ST_SHIFT;
        end else if (cnt_r == CNT_ZERO) begin
          // Final bit: reload for a gapless next frame, otherwise drain to idle.
          if (accept_s) begin
            state_nxt_s = ST_SHIFT;
            shreg_nxt_s = bus.data_in;
            cnt_nxt_s   = CNT_MAX;
          end else begin
            state_nxt_s = ST_IDLE;
            shreg_nxt_s = {shreg_r[WIDTH-2:0], 1'b0};
            cnt_nxt_s   = CNT_ZERO;
          end
        end else begin
          shreg_nxt_s = {shreg_r[WIDTH-2:0], 1'b0};
          cnt_nxt_s   = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        shreg_nxt_s = {WIDTH{1'b0}};
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, shift register and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      shreg_r <= {WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      shreg_r <= shreg_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Serial outputs are registered from the next-state view so they line up with shreg/cnt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      serial_out_r <= 1'b0;
      bit_valid_r  <= 1'b0;
      last_bit_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      serial_out_r <= (state_nxt_s == ST_SHIFT) & shreg_nxt_s[WIDTH-1];
      bit_valid_r  <= (state_nxt_s == ST_SHIFT);
      last_bit_r   <= (state_nxt_s == ST_SHIFT) & (cnt_nxt_s == CNT_ZERO);
      busy_r       <= (state_nxt_s != ST_IDLE);
    end
  end

  assign bus.data_ready = data_ready_s;
  assign bus.serial_out = serial_out_r;
  assign bus.bit_valid  = bit_valid_r;
  assign bus.last_bit   = last_bit_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_piso_readout_tx.sv
// Self-checking bench for piso_readout_tx: scoreboard of expected serial bits
// filled on every accepted frame and drained as bits leave the transmitter.
module tb_piso_readout_tx;

  localparam int W = 512;

  logic clk;
  logic reset;

  piso_readout_tx_if #(.WIDTH(W)) bus ();

  piso_readout_tx #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected stream entries: {bit, last_flag}
  logic [1:0]   exp_q[$];
  logic [W-1:0] rx_shift = '0;
  logic [W-1:0] rx_frame = '0;
  int           vcount   = 0;  // bits consumed (non-hold cycles)
  int           bvcount  = 0;  // cycles with bit_valid high
  int           starts   = 0;  // rising edges of bit_valid
  logic         prev_bv  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rand_frame();
    logic [W-1:0] f;
    for (int k = 0; k < W / 32; k++) f[k*32 +: 32] = $urandom;
    return f;
  endfunction

  // Monitor and scoreboard, sampled on the inactive edge.
  always @(negedge clk) begin
    logic [1:0] e;
    if (!reset) begin
      check_val("ready", {31'd0, bus.data_ready},
                {31'd0, (exp_q.size() == 0) || (exp_q.size() == 1 && !bus.hold)});
      if (exp_q.size() == 0) begin
        check_val("idle_bit_valid", {31'd0, bus.bit_valid}, 32'd0);
        check_val("idle_busy", {31'd0, bus.busy}, 32'd0);
        check_val("idle_serial", {31'd0, bus.serial_out}, 32'd0);
      end else begin
        e = exp_q[0];
        check_val("bit_valid", {31'd0, bus.bit_valid}, 32'd1);
        check_val("busy", {31'd0, bus.busy}, 32'd1);
        check_val("serial", {31'd0, bus.serial_out}, {31'd0, e[1]});
        check_val("last_bit", {31'd0, bus.last_bit}, {31'd0, e[0]});
        if (!bus.hold) begin
          rx_shift = {rx_shift[W-2:0], bus.serial_out};
          vcount++;
          void'(exp_q.pop_front());
          if (e[0]) rx_frame = rx_shift;
        end
      end
      if (bus.bit_valid) bvcount++;
      if (bus.bit_valid && !prev_bv) starts++;
      prev_bv = bus.bit_valid;
      if (bus.data_valid && bus.data_ready) begin
        for (int i = W - 1; i >= 0; i--) exp_q.push_back({bus.data_in[i], (i == 0)});
      end
    end else begin
      prev_bv = 1'b0;
    end
  end

  task automatic send_frame(input logic [W-1:0] f, input bit keep_valid);
    bit ok;
    ok = 1'b0;
    bus.data_in    = f;
    bus.data_valid = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (bus.data_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_val("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!keep_valid) begin
      bus.data_valid = 1'b0;
      bus.data_in    = rand_frame();
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!bus.busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_val("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] f;
    int           base_v, base_bv, base_st;
    int           idx[12];

    reset          = 1'b1;
    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    bus.hold       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_serial", {31'd0, bus.serial_out}, 32'd0);
    check_val("rst_bit_valid", {31'd0, bus.bit_valid}, 32'd0);
    check_val("rst_last", {31'd0, bus.last_bit}, 32'd0);
    check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("rst_ready", {31'd0, bus.data_ready}, 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // MSB-only frame, accepted with hold high in idle
    f = '0;
    f[W-1] = 1'b1;
    bus.hold = 1'b1;
    base_v = vcount;
    send_frame(f, 1'b0);
    bus.hold = 1'b0;
    wait_idle();
    check_val("t1_bits", vcount - base_v, W);
    check_val("t1_rx", {31'd0, rx_frame == f}, 32'd1);
    check_val("t1_busy_after", {31'd0, bus.busy}, 32'd0);

    // One-hot frames as seen by a serial-in receiver
    idx = '{0, 1, 2, 7, 100, 255, 256, 300, 509, 510, 511, 0};
    idx[11] = $urandom_range(W - 1, 0);
    foreach (idx[j]) begin
      f = '0;
      f[idx[j]] = 1'b1;
      send_frame(f, 1'b0);
      wait_idle();
      check_val("t2_onehot_bit", {31'd0, rx_frame[idx[j]]}, 32'd1);
      check_val("t2_popcount", $countones(rx_frame), 32'd1);
    end

    // Back-to-back A5/5A frames with data_valid held high
    base_bv = bvcount;
    base_st = starts;
    send_frame({(W/8){8'hA5}}, 1'b1);
    send_frame({(W/8){8'h5A}}, 1'b0);
    wait_idle();
    check_val("t3_valid_cycles", bvcount - base_bv, 2 * W);
    check_val("t3_no_gap", starts - base_st, 32'd1);
    check_val("t3_second_frame", {31'd0, rx_frame == {(W/8){8'h5A}}}, 32'd1);

    // Three-cycle hold at bit 100
    f = rand_frame();
    base_bv = bvcount;
    base_v  = vcount;
    send_frame(f, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    bus.hold = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.hold = 1'b0;
    wait_idle();
    check_val("t4_valid_cycles", bvcount - base_bv, W + 3);
    check_val("t4_bits", vcount - base_v, W);
    check_val("t4_data", {31'd0, rx_frame == f}, 32'd1);

    // Reset mid-frame at bit 200, then a clean new frame
    send_frame(rand_frame(), 1'b0);
    repeat (200) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_val("t5_serial", {31'd0, bus.serial_out}, 32'd0);
    check_val("t5_bit_valid", {31'd0, bus.bit_valid}, 32'd0);
    check_val("t5_last", {31'd0, bus.last_bit}, 32'd0);
    check_val("t5_busy", {31'd0, bus.busy}, 32'd0);
    check_val("t5_ready", {31'd0, bus.data_ready}, 32'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    f = rand_frame();
    base_v = vcount;
    send_frame(f, 1'b0);
    wait_idle();
    check_val("t5_bits", vcount - base_v, W);
    check_val("t5_data", {31'd0, rx_frame == f}, 32'd1);

    // No data_valid: random data and hold never start a frame
    base_bv = bvcount;
    for (int n = 0; n < 200; n++) begin
      bus.data_in = rand_frame();
      bus.hold    = $urandom_range(1, 0);
      @(posedge clk);
      #1;
    end
    bus.hold = 1'b0;
    check_val("t6_no_valid", bvcount - base_bv, 32'd0);
    check_val("t6_busy", {31'd0, bus.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
